// File: rtl/office_hours_pkg.sv
// office_hours_pkg: shared types, LED constants and 24-hour conversion for the office-hours arbiter
package office_hours_pkg;
  typedef enum logic [1:0] {IDLE, STUDENT, PROF} arb_state_t;
  typedef enum logic {STATUS, OVERRIDE} disp_mode_t;
  localparam logic [15:0] LED_ALL_ON = 16'hFFFF;
  localparam logic [15:0] LED_ALL_OFF = 16'h0000;
  function automatic logic [4:0] to_h24(input logic [3:0] hour, input logic pm);
    return (hour == 4'd12 ? 5'd0 : {1'b0, hour}) + (pm ? 5'd12 : 5'd0);
  endfunction
endpackage

// File: rtl/office_hours_arbiter_hour_keeper.sv
// hour_keeper: 12-hour clock with AM/PM flag, advanced by a one-cycle tick strobe
module hour_keeper (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  output logic [3:0] hour,
  output logic       pm
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hour <= 4'd12;
      pm <= 1'b0;
    end else if (tick) begin
      hour <= hour == 4'd12 ? 4'd1 : hour + 4'd1;
      pm <= hour == 4'd11 ? ~pm : pm;
    end
endmodule

// File: rtl/office_hours_arbiter.sv
// office_hours_arbiter: room arbiter between student and professor with office-hours window, button-toggled LED status bus
module office_hours_arbiter
  import office_hours_pkg::*;
#(
  parameter int OPEN_H = 9,
  parameter int CLOSE_H = 17,
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        btnu,
  input  logic        student,
  input  logic        prof,
  input  logic [8:0]  sw,
  output logic [3:0]  hour,
  output logic        pm,
  output logic        grant_student,
  output logic        grant_prof,
  output logic [15:0] led
);
  arb_state_t state, nxt;
  disp_mode_t mode;
  logic [4:0] h24;
  logic       in_window, elig, last_prof, btn_rise;
  logic [7:0] cnt;
  logic [2:0] sync;
  hour_keeper u_hour_keeper (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick),
    .hour (hour),
    .pm   (pm)
  );
  assign h24 = to_h24(hour, pm);
  assign in_window = h24 >= 5'(OPEN_H) && h24 < 5'(CLOSE_H);
  assign elig = student && in_window;
  assign btn_rise = sync[1] && !sync[2];
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = prof && elig ? (last_prof ? STUDENT : PROF) : prof ? PROF : elig ? STUDENT : IDLE;
      STUDENT: nxt = !elig ? (prof ? PROF : IDLE) : prof && cnt == 8'(MAX_HOLD - 1) ? PROF : STUDENT;
      PROF:    nxt = prof ? PROF : elig ? STUDENT : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      grant_student <= 1'b0;
      grant_prof <= 1'b0;
      last_prof <= 1'b0;
      cnt <= 8'd0;
      sync <= 3'd0;
      mode <= STATUS;
      led <= LED_ALL_OFF;
    end else begin
      state <= nxt;
      grant_student <= nxt == STUDENT;
      grant_prof <= nxt == PROF;
      if (nxt != state && nxt != IDLE) last_prof <= nxt == PROF;
      cnt <= state == STUDENT && nxt == STUDENT && prof ? cnt + 8'd1 : 8'd0;
      sync <= {sync[1:0], btnu};
      mode <= btn_rise ? (mode == STATUS ? OVERRIDE : STATUS) : mode;
      led <= mode == STATUS ? {sw, hour, pm, grant_prof, grant_student} : grant_prof ? LED_ALL_ON : LED_ALL_OFF;
    end
endmodule

// File: tb/tb_office_hours_arbiter.sv
// tb_office_hours_arbiter: randomized and directed checks of office_hours_arbiter against a behavioural model
module tb_office_hours_arbiter;
  localparam int OPEN_H = 9;
  localparam int CLOSE_H = 17;
  localparam int MAX_HOLD = 8;
  logic        clk = 0, rst_n = 1, tick = 0, btnu = 0, student = 0, prof = 0;
  logic [8:0]  sw = 0;
  logic [3:0]  hour;
  logic        pm, grant_student, grant_prof;
  logic [15:0] led;
  int vectors = 0, miscompares = 0;
  int m_h24, m_owner, m_last, m_wait;
  bit m_mode;
  bit [2:0] m_btn;
  logic [15:0] m_led;
  office_hours_arbiter #(.OPEN_H(OPEN_H), .CLOSE_H(CLOSE_H), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btnu(btnu), .student(student), .prof(prof), .sw(sw),
    .hour(hour), .pm(pm), .grant_student(grant_student), .grant_prof(grant_prof), .led(led)
  );
  always #5 clk = ~clk;
  function automatic int m_hour();
    return m_h24 % 12 == 0 ? 12 : m_h24 % 12;
  endfunction
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_h24 = 0; m_owner = 0; m_last = 1; m_wait = 0; m_mode = 0; m_btn = 0; m_led = 16'h0000;
  endtask
  // owner: 0 none, 1 student, 2 professor
  task automatic model_edge();
    bit elig, toggle;
    int no;
    logic [3:0] hh;
    logic [15:0] nl;
    elig = student && m_h24 >= OPEN_H && m_h24 < CLOSE_H;
    hh = 4'(m_hour());
    nl = m_mode ? (m_owner == 2 ? 16'hFFFF : 16'h0000) : {sw, hh, m_h24 >= 12, m_owner == 2, m_owner == 1};
    toggle = m_btn[1] && !m_btn[2];
    m_btn = {m_btn[1:0], btnu};
    no = m_owner;
    if (m_owner == 0) no = prof && elig ? (m_last == 1 ? 2 : 1) : prof ? 2 : elig ? 1 : 0;
    else if (m_owner == 1) begin
      if (!elig) no = prof ? 2 : 0;
      else if (prof) begin
        m_wait++;
        if (m_wait == MAX_HOLD) no = 2;
      end else m_wait = 0;
    end else if (!prof) no = elig ? 1 : 0;
    if (no != m_owner) begin
      m_wait = 0;
      if (no != 0) m_last = no;
    end
    m_owner = no;
    if (tick) m_h24 = (m_h24 + 1) % 24;
    m_led = nl;
    m_mode ^= toggle;
  endtask
  task automatic check_all();
    chk("hour", 16'(hour), 16'(m_hour()));
    chk("pm", 16'(pm), 16'(m_h24 >= 12));
    chk("grant_student", 16'(grant_student), 16'(m_owner == 1));
    chk("grant_prof", 16'(grant_prof), 16'(m_owner == 2));
    chk("led", led, m_led);
    chk("exclusive", 16'(grant_student & grant_prof), 16'h0);
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask
  task automatic do_reset();
    rst_n = 0;
    #1;
    chk("rst_grant_prof", 16'(grant_prof), 16'h0);
    chk("rst_grant_student", 16'(grant_student), 16'h0);
    chk("rst_led", led, 16'h0000);
    chk("rst_hour", 16'(hour), 16'd12);
    chk("rst_pm", 16'(pm), 16'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    #2;
    do_reset();
    step();
    chk("led_rst_sw0", led, 16'h0060);
    sw = 9'h1FF;
    step();
    chk("led_sw1ff", led, 16'hFFE0);
    sw = 0;
    tick = 1;
    repeat (12) step();
    chk("hr12pm", {11'h0, pm, hour}, {11'h0, 1'b1, 4'd12});
    step();
    chk("hr1pm", {11'h0, pm, hour}, {11'h0, 1'b1, 4'd1});
    tick = 0;
    do_reset();
    tick = 1;
    repeat (8) step();
    tick = 0;
    student = 1;
    step();
    step();
    chk("8am_no_grant", 16'(grant_student), 16'h0);
    tick = 1;
    step();
    tick = 0;
    chk("9am_tick_edge", 16'(grant_student), 16'h0);
    step();
    chk("9am_grant", 16'(grant_student), 16'h1);
    tick = 1;
    repeat (8) step();
    tick = 0;
    chk("5pm_edge_held", 16'(grant_student), 16'h1);
    step();
    chk("5pm_revoked", 16'(grant_student), 16'h0);
    student = 0;
    do_reset();
    tick = 1;
    repeat (10) step();
    tick = 0;
    student = 1;
    step();
    chk("10am_student", 16'(grant_student), 16'h1);
    prof = 1;
    repeat (MAX_HOLD - 1) begin
      step();
      chk("hold_student", 16'(grant_student), 16'h1);
    end
    step();
    chk("hold_handover", 16'(grant_prof), 16'h1);
    prof = 0;
    step();
    chk("prof_release", 16'(grant_student), 16'h1);
    student = 0;
    step();
    student = 1;
    prof = 1;
    step();
    chk("rr_prof_first", 16'(grant_prof), 16'h1);
    prof = 0;
    step();
    chk("rr_student_next", 16'(grant_student), 16'h1);
    student = 0;
    prof = 1;
    step();
    chk("prof_for_button", 16'(grant_prof), 16'h1);
    btnu = 1;
    step();
    btnu = 0;
    repeat (3) step();
    chk("ovr_on", led, 16'hFFFF);
    prof = 0;
    step();
    step();
    chk("ovr_off", led, 16'h0000);
    btnu = 1;
    step();
    btnu = 0;
    repeat (3) step();
    chk("status_back", led, 16'h0050);
    prof = 1;
    step();
    chk("prof_before_reset", 16'(grant_prof), 16'h1);
    do_reset();
    prof = 0;
    step();
    chk("idle_after_reset", 16'(grant_prof), 16'h0);
    for (int i = 0; i < 4000; i++) begin
      tick = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 7) == 0) student = !student;
      if ($urandom_range(0, 5) == 0) prof = !prof;
      btnu = $urandom_range(0, 19) == 0;
      sw = 9'($urandom);
      if ($urandom_range(0, 599) == 0) do_reset();
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
